// File: rtl/lampFPU_pkg.sv
// LAMP FPU shared definitions: float field widths and square-root arbiter types.
package lampFPU_pkg;

  localparam int unsigned LAMP_FLOAT_F_DW  = 7;
  localparam int unsigned LAMP_FLOAT_S_DW  = 1 + LAMP_FLOAT_F_DW;
  localparam int unsigned LAMP_SQRT_RES_DW = 2 * LAMP_FLOAT_S_DW;

  localparam int unsigned SQRT_ARB_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    SQRT_ARB_IDLE  = 2'd0,
    SQRT_ARB_ISSUE = 2'd1,
    SQRT_ARB_WAIT  = 2'd2,
    SQRT_ARB_RESP  = 2'd3
  } sqrt_arb_state_t;

endpackage

// File: rtl/lampfpu_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module lampfpu_rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic              found;
  int unsigned       cand;
  logic [IDX_W-1:0]  cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand     = (32'(ptr) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/lampfpu_sqrt_arbiter.sv
// Round-robin scheduler sharing one LAMP FPU sqrt unit among N_REQ requesters.
// Optional watchdog abort of a stuck unit: define LAMP_SQRT_ARB_TIMEOUT_EN.
module lampfpu_sqrt_arbiter
  import lampFPU_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = SQRT_ARB_TIMEOUT_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_i,
  input  logic [N_REQ*LAMP_FLOAT_S_DW-1:0] s_i,
  input  logic [N_REQ-1:0]                is_exp_odd_i,
  input  logic [N_REQ-1:0]                invSqrt_i,
  input  logic [N_REQ-1:0]                special_case_i,
  output logic [N_REQ-1:0]                gnt_o,
  output logic [N_REQ-1:0]                done_o,
  output logic [LAMP_SQRT_RES_DW-1:0]     res_o,
  output logic                            err_o,
  output logic                            busy_o,
  output logic                            sq_doSqrt_o,
  output logic [LAMP_FLOAT_S_DW-1:0]      sq_s_o,
  output logic                            sq_is_exp_odd_o,
  output logic                            sq_invSqrt_o,
  output logic                            sq_special_case_o,
  output logic                            sq_rst_o,
  input  logic                            sq_valid_i,
  input  logic [LAMP_SQRT_RES_DW-1:0]     sq_res_i
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned S_W   = LAMP_FLOAT_S_DW;
  localparam int unsigned R_W   = LAMP_SQRT_RES_DW;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("lampfpu_sqrt_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  sqrt_arb_state_t   state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              do_sqrt_q, do_sqrt_d;
  logic              busy_q, busy_d;
  logic [R_W-1:0]    res_q, res_d;
  logic [S_W-1:0]    s_q, s_d;
  logic              odd_q, odd_d;
  logic              inv_q, inv_d;
  logic              spc_q, spc_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic [S_W-1:0]    s_sel;

`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
`endif

  lampfpu_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Significand slice of the requester the arbiter is about to grant.
  always_comb begin
    s_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (arb_idx == IDX_W'(k)) s_sel = s_i[k*S_W +: S_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    s_d       = s_q;
    odd_d     = odd_q;
    inv_d     = inv_q;
    spc_d     = spc_q;
    res_d     = res_q;
    gnt_d     = '0;
    done_d    = '0;
    do_sqrt_d = 1'b0;
`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
    abort_d   = 1'b0;
`endif
    case (state_q)
      SQRT_ARB_IDLE: begin
        if (|req_i) begin
          state_d   = SQRT_ARB_ISSUE;
          idx_d     = arb_idx;
          ptr_d     = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          s_d       = s_sel;
          odd_d     = is_exp_odd_i[arb_idx];
          inv_d     = invSqrt_i[arb_idx];
          spc_d     = special_case_i[arb_idx];
          gnt_d     = arb_gnt;
          do_sqrt_d = 1'b1;
        end
      end
      SQRT_ARB_ISSUE: begin
        state_d = SQRT_ARB_WAIT;
`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      SQRT_ARB_WAIT: begin
        // A result arriving on the timeout cycle still wins over the abort.
        if (sq_valid_i) begin
          state_d = SQRT_ARB_RESP;
          res_d   = sq_res_i;
          done_d  = N_REQ'(1) << idx_q;
`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = SQRT_ARB_RESP;
          res_d   = '0;
          err_d   = 1'b1;
          abort_d = 1'b1;
          done_d  = N_REQ'(1) << idx_q;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      SQRT_ARB_RESP: state_d = SQRT_ARB_IDLE;
      default:       state_d = SQRT_ARB_IDLE;
    endcase
    busy_d = (state_d != SQRT_ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SQRT_ARB_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      do_sqrt_q <= 1'b0;
      busy_q    <= 1'b0;
      res_q     <= '0;
      s_q       <= '0;
      odd_q     <= 1'b0;
      inv_q     <= 1'b0;
      spc_q     <= 1'b0;
`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      do_sqrt_q <= do_sqrt_d;
      busy_q    <= busy_d;
      res_q     <= res_d;
      s_q       <= s_d;
      odd_q     <= odd_d;
      inv_q     <= inv_d;
      spc_q     <= spc_d;
`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
`endif
    end
  end

  assign gnt_o             = gnt_q;
  assign done_o            = done_q;
  assign res_o             = res_q;
  assign busy_o            = busy_q;
  assign sq_doSqrt_o       = do_sqrt_q;
  assign sq_s_o            = s_q;
  assign sq_is_exp_odd_o   = odd_q;
  assign sq_invSqrt_o      = inv_q;
  assign sq_special_case_o = spc_q;

  // The unit resets together with the arbiter, and also after a watchdog abort.
`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
  assign err_o    = err_q;
  assign sq_rst_o = rst | abort_q;
`else
  assign err_o    = 1'b0;
  assign sq_rst_o = rst;
`endif

endmodule

// File: tb/tb_lampfpu_sqrt_arbiter.sv
// Scoreboard bench for lampfpu_sqrt_arbiter with a programmable-latency sqrt stub.
module tb_lampfpu_sqrt_arbiter;
  import lampFPU_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = LAMP_FLOAT_S_DW;
  localparam int unsigned RW = LAMP_SQRT_RES_DW;
  localparam int          TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, is_exp_odd_i, invSqrt_i, special_case_i;
  logic [N*SW-1:0] s_i;
  logic [N-1:0]    gnt_o, done_o;
  logic [RW-1:0]   res_o;
  logic            err_o, busy_o, sq_doSqrt_o;
  logic [SW-1:0]   sq_s_o;
  logic            sq_is_exp_odd_o, sq_invSqrt_o, sq_special_case_o, sq_rst_o;
  logic            sq_valid_i;
  logic [RW-1:0]   sq_res_i;

  always #5 clk = ~clk;

  lampfpu_sqrt_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .s_i(s_i), .is_exp_odd_i(is_exp_odd_i),
    .invSqrt_i(invSqrt_i), .special_case_i(special_case_i), .gnt_o(gnt_o),
    .done_o(done_o), .res_o(res_o), .err_o(err_o), .busy_o(busy_o),
    .sq_doSqrt_o(sq_doSqrt_o), .sq_s_o(sq_s_o), .sq_is_exp_odd_o(sq_is_exp_odd_o),
    .sq_invSqrt_o(sq_invSqrt_o), .sq_special_case_o(sq_special_case_o),
    .sq_rst_o(sq_rst_o), .sq_valid_i(sq_valid_i), .sq_res_i(sq_res_i)
  );

  // Sqrt stub: valid L cycles after doSqrt (L=0 never answers), res={s,8'h00}^inv.
  int            stub_lat = 1;
  int            stub_cnt = 0;
  logic          stub_active = 1'b0;
  logic [SW-1:0] stub_s = '0;
  logic          stub_inv = 1'b0;
  logic          inject_valid;
  logic [RW-1:0] inject_res;

  always @(posedge clk) begin
    if (sq_rst_o) begin
      stub_active <= 1'b0;
      stub_cnt    <= 0;
    end else if (sq_doSqrt_o) begin
      stub_active <= 1'b1;
      stub_cnt    <= stub_lat;
      stub_s      <= sq_s_o;
      stub_inv    <= sq_invSqrt_o;
    end else if (stub_active && stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign sq_valid_i = (stub_active && stub_cnt == 1) || inject_valid;
  assign sq_res_i   = inject_valid ? inject_res : ({stub_s, 8'h00} ^ RW'(stub_inv));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [N-1:0]  gnt;
    logic [SW-1:0] s;
    logic          odd, inv, spc;
  } gexp_t;

  typedef struct {
    int            cyc;
    logic [N-1:0]  done;
    logic [RW-1:0] res;
    logic          err;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  int errors = 0;
  int checks = 0;
  int mptr = 0;
  logic [RW-1:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every grant and every done against the scoreboard queues.
  always @(negedge clk) begin
    gexp_t g;
    dexp_t d;
    if (!rst) begin
      if (gnt_o != '0 || sq_doSqrt_o) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", {27'd0, sq_doSqrt_o, gnt_o}, 32'd0);
        end else begin
          g = gq.pop_front();
          chk("gnt_onehot", 32'(gnt_o), 32'(g.gnt));
          chk("gnt_dosqrt", 32'(sq_doSqrt_o), 32'd1);
          chk("gnt_cycle", cyc, g.cyc);
          chk("gnt_operands", {21'd0, sq_s_o, sq_is_exp_odd_o, sq_invSqrt_o, sq_special_case_o},
              {21'd0, g.s, g.odd, g.inv, g.spc});
        end
      end
      if (done_o != '0) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(done_o), 32'd0);
        end else begin
          d = dq.pop_front();
          chk("done_onehot", 32'(done_o), 32'(d.done));
          chk("done_cycle", cyc, d.cyc);
          chk("done_res", 32'(res_o), 32'(d.res));
          chk("done_err", 32'(err_o), 32'(d.err));
        end
      end
    end
  end

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mptr + k) % N;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic set_ops(input int idx, input logic [SW-1:0] s, input logic odd,
                         input logic inv, input logic spc);
    s_i[idx*SW +: SW]   = s;
    is_exp_odd_i[idx]   = odd;
    invSqrt_i[idx]      = inv;
    special_case_i[idx] = spc;
  endtask

  task automatic push_op(input int idx, input int gcyc, input int lat, input logic tmo,
                         input logic with_done);
    gexp_t g;
    dexp_t d;
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    g.cyc = gcyc; g.gnt = oh; g.s = s_i[idx*SW +: SW];
    g.odd = is_exp_odd_i[idx]; g.inv = invSqrt_i[idx]; g.spc = special_case_i[idx];
    gq.push_back(g);
    d.cyc  = tmo ? gcyc + 1 + TO : gcyc + 1 + lat;
    d.done = oh;
    d.res  = tmo ? '0 : ({g.s, 8'h00} ^ RW'(g.inv));
    d.err  = tmo;
    if (with_done) begin
      dq.push_back(d);
      last_res = d.res;
    end
    mptr = (idx + 1) % N;
  endtask

  // All stimulus tasks run at posedge+1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      if (!busy_o) break;
      step();
    end
    if (i == 200) chk("wait_idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic wait_gnt();
    int i;
    for (i = 0; i < 20; i++) begin
      if (gnt_o != '0) break;
      step();
    end
    if (i == 20) chk("wait_gnt_timeout", 32'(gnt_o), 32'hF);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 100; i++) begin
      if (done_o != '0) break;
      step();
    end
    if (i == 100) chk("wait_done_timeout", 32'(done_o), 32'hF);
  endtask

  task automatic run_op(input logic [N-1:0] r, input int lat, input logic tmo);
    int idx;
    wait_idle();
    stub_lat = lat;
    idx = pick(r);
    push_op(idx, cyc + 1, lat, tmo, 1'b1);
    req_i = r;
    step();
    wait_gnt();
    req_i = '0;
    wait_done();
    if (tmo) begin
      chk("timeout_sq_rst_pulse", 32'(sq_rst_o), 32'd1);
      step();
      chk("timeout_sq_rst_end", 32'(sq_rst_o), 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_dosqrt"}, 32'(sq_doSqrt_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_res"}, 32'(res_o), 32'd0);
    chk({tag, "_sq_ops"}, {21'd0, sq_s_o, sq_is_exp_odd_o, sq_invSqrt_o, sq_special_case_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int ndone;
    rst = 1'b1; req_i = '0; s_i = '0; is_exp_odd_i = '0; invSqrt_i = '0;
    special_case_i = '0; inject_valid = 1'b0; inject_res = '0;
    repeat (3) step();
    check_reset_values("reset");
    chk("reset_sq_rst", 32'(sq_rst_o), 32'd1);
    rst = 1'b0;
    step();
    chk("idle_sq_rst", 32'(sq_rst_o), 32'd0);

    // Single request, L=9: grant at cycle 1, done at cycle 11, res B500.
    set_ops(0, 8'hB5, 1'b0, 1'b0, 1'b0);
    run_op(4'b0001, 9, 1'b0);

    // Reset in WAIT cycle 4: no done, sq_rst_o follows rst, outputs back to reset values.
    set_ops(1, 8'h5A, 1'b1, 1'b1, 1'b0);
    wait_idle();
    stub_lat = 20;
    push_op(pick(4'b0010), cyc + 1, 20, 1'b0, 1'b0);
    req_i = 4'b0010;
    step();
    wait_gnt();
    req_i = '0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("midop_sq_rst", 32'(sq_rst_o), 32'd1);
    step();
    check_reset_values("midop");
    rst = 1'b0;
    mptr = 0;
    repeat (25) step();

    // Round robin with req held: grants 0,1,2,3,0, each result from its own slice.
    set_ops(0, 8'h11, 1'b1, 1'b0, 1'b0);
    set_ops(1, 8'h22, 1'b0, 1'b1, 1'b0);
    set_ops(2, 8'h33, 1'b1, 1'b0, 1'b0);
    set_ops(3, 8'h44, 1'b0, 1'b1, 1'b0);
    wait_idle();
    stub_lat = 3;
    g = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      push_op(pick(4'b1111), g, 3, 1'b0, 1'b1);
      g = g + 3 + 3;
    end
    req_i = 4'b1111;
    ndone = 0;
    for (int i = 0; i < 100 && ndone < 5; i++) begin
      step();
      if (done_o != '0) ndone++;
    end
    chk("rr_done_count", ndone, 5);
    req_i = '0;

    // Pointer wrap: grant 3, then 1001 -> 0, then 1001 -> 3.
    run_op(4'b1000, 2, 1'b0);
    run_op(4'b1001, 2, 1'b0);
    run_op(4'b1001, 2, 1'b0);

    // Stray valid in IDLE is ignored and res_o holds; special case with L=1.
    wait_idle();
    inject_res = 16'hDEAD;
    inject_valid = 1'b1;
    step();
    inject_valid = 1'b0;
    step();
    step();
    chk("stray_valid_res_hold", 32'(res_o), 32'(last_res));
    chk("stray_valid_busy", 32'(busy_o), 32'd0);
    set_ops(2, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op(4'b0100, 1, 1'b0);

`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
    // Stub never answers: watchdog abort, then a normal operation.
    set_ops(1, 8'h66, 1'b0, 1'b1, 1'b0);
    run_op(4'b0010, 0, 1'b0 | 1'b1);
    set_ops(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    run_op(4'b0001, 4, 1'b0);
`endif

    repeat (5) step();
    chk("gnt_queue_drained", gq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lampfpu_sqrt_arbiter.md
# lampfpu_sqrt_arbiter

Round-robin scheduler that shares one LAMP FPU square-root unit among `N_REQ` requesters. For each accepted request it latches the operands and issues a single `doSqrt` pulse to the unit. It then waits for the unit's `valid` and routes the 16-bit result back to the owning requester as a one-cycle `done` pulse. It sits between the FPU issue logic (or several FPU lanes) and the square-root datapath, and owns that datapath's issue and reset sequencing.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, default 64: watchdog limit in cycles. Used only with `LAMP_SQRT_ARB_TIMEOUT_EN`.
- `clk` input, 1: clock.
- `rst` input, 1: reset, synchronous, active-high.
- `req_i` input, `N_REQ`: per-requester request level, held until `gnt_o[i]`.
- `s_i` input, `N_REQ`×(1+`LAMP_FLOAT_F_DW`): packed significands, slice i belongs to requester i.
- `is_exp_odd_i` input, `N_REQ`: per-requester odd-exponent flag.
- `invSqrt_i` input, `N_REQ`: per-requester inverse-sqrt select.
- `special_case_i` input, `N_REQ`: per-requester special-case flag.
- `gnt_o` output, `N_REQ`: one-hot, one-cycle pulse; operands of requester i captured.
- `done_o` output, `N_REQ`: one-hot, one-cycle pulse; `res_o`/`err_o` valid for requester i.
- `res_o` output, 2×(1+`LAMP_FLOAT_F_DW`): result, shared by all requesters.
- `err_o` output, 1: qualifies `done_o`; 1 = operation aborted by the watchdog.
- `busy_o` output, 1: the arbiter is not in IDLE.
- `sq_doSqrt_o` output, 1: start pulse to the sqrt unit.
- `sq_s_o`, `sq_is_exp_odd_o`, `sq_invSqrt_o`, `sq_special_case_o` outputs, widths as the unit's inputs: latched operands, stable from ISSUE until the unit's `valid`.
- `sq_rst_o` output, 1: reset to the sqrt unit.
- `sq_valid_i` input, 1: valid from the sqrt unit.
- `sq_res_i` input, 2×(1+`LAMP_FLOAT_F_DW`): result from the sqrt unit.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If `req_i` is nonzero, pick the first set bit at or after `ptr`, wrapping modulo `N_REQ`.
  - Latch that requester's index and operands; go to ISSUE.
  - Set `ptr` to (index+1) mod `N_REQ`.
  - If no request, stay in IDLE.
- **ISSUE** (exactly 1 cycle):
  - `gnt_o[idx]`=1 and `sq_doSqrt_o`=1.
  - Go to WAIT.
- **WAIT:**
  - On `sq_valid_i`: latch `sq_res_i` into `res_o`, set `err_o`=0, go to RESP.
  - `sq_valid_i` seen in any other state is ignored.
- **RESP** (1 cycle):
  - `done_o[idx]`=1.
  - Go to IDLE; IDLE may arbitrate on its first cycle.
- **Special-case operands:** no separate handling. The unit returns `valid` the cycle after `doSqrt`, so the result path is the same as for normal operands.
- **Requester handshake:**
  - A requester must deassert `req_i` the cycle after `gnt_o`. A held `req_i` counts as a new request at the next IDLE.
  - `req_i` changes during ISSUE, WAIT and RESP are not sampled.
- **`res_o` and `err_o`:** hold their values between `done_o` pulses.
- **Reset values:** state IDLE, `ptr`=0. `gnt_o`, `done_o`, `sq_doSqrt_o`, `err_o` and `busy_o` are 0. `res_o` and all `sq_*` operand outputs are 0.
- **Reset mid-operation:** return to IDLE with no `done_o`. `sq_rst_o` is asserted in the same cycle, so the unit resets with the arbiter.
- **`sq_rst_o`:** combinational OR of `rst` and the registered abort pulse.

## Timing
- `req_i` sampled in IDLE at cycle 0.
- Cycle 1: `gnt_o` and `sq_doSqrt_o`.
- Unit `valid` arrives at cycle 1+L (L = unit latency).
- `done_o` at cycle 2+L.
- Back-to-back issue: next `gnt_o` no earlier than 2 cycles after `done_o`.
- Total arbiter overhead: 3 cycles per operation on top of L.

## Configuration
- Macro: `LAMP_SQRT_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYC` without `sq_valid_i`: assert `sq_rst_o` for 1 cycle, set `res_o`=0 and `err_o`=1, go to RESP.
  - If `sq_valid_i` arrives in the same cycle the count is reached, `valid` wins: no abort.
- **Undefined:**
  - No counter.
  - `err_o` is tied to 0 and `sq_rst_o` equals `rst`.
  - WAIT is unbounded.

## Structure
- Add to `lampFPU_pkg`:
  - `sqrt_arb_state_t`, a 2-bit enum with the four states.
  - `SQRT_ARB_TIMEOUT_DEF`, value 64.
- Sub-module `lampfpu_rr_arbiter`:
  - Combinational.
  - Inputs: `req` and `ptr`. Outputs: one-hot `gnt` and its encoded index.
  - The pointer register stays in the parent.

## Test plan
Benches use a stub sqrt unit with programmable L that returns `res` = {`s`, 8'h00} ^ {15'b0, `invSqrt`}.
- Single request: `req_i`=4'b0001, `s_i[0]`=8'hB5, L=9 -> `gnt_o`=0001 at cycle 1, `sq_doSqrt_o` exactly 1 cycle, `done_o`=0001 at cycle 11, `res_o`=16'hB500, `err_o`=0.
- Round robin: `req_i`=4'b1111 held continuously -> grant order 0,1,2,3,0 and each `done_o` matches its own `s_i` slice.
- Pointer wrap: last grant to 3, then `req_i`=4'b1001 -> grant to 0; then `req_i`=4'b1001 again -> grant to 3.
- Special case: `special_case_i[2]`=1, L=1 -> `done_o[2]` 3 cycles after `req_i`; `sq_valid_i` pulsed during IDLE is ignored.
- Reset at WAIT cycle 4 -> no `done_o`, `sq_rst_o`=1 in the reset cycle, all outputs at reset values, `ptr`=0.
- Timeout (`LAMP_SQRT_ARB_TIMEOUT_EN` defined, `TIMEOUT_CYC`=16, stub never responds) -> `sq_rst_o` 1-cycle pulse, `done_o[idx]` with `err_o`=1 and `res_o`=0; next request then completes normally.
